// File: rtl/acc_pkg.sv
// Shared types and width/bound helpers for the signed carry-save
// frame accumulator.
package acc_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        RESOLVE,
        HOLD
    } state_t;

    function automatic int width_i(input int wp, input int wn);
        return wp + wn;
    endfunction

    function automatic longint sat_max(input int wa);
        return (longint'(1) <<< (wa - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int wa);
        return -(longint'(1) <<< (wa - 1));
    endfunction

endpackage

// File: rtl/Add.sv
// Carry-propagate adder, modulo 2^width; speed 0 is an explicit ripple
// chain, higher speeds leave the architecture to synthesis.
module Add #(
    parameter int width = 8,
    parameter int speed = 0
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic [width-1:0] S
);

    generate
        if (speed == 0) begin : g_ripple
            logic [width-1:0] c;
            always_comb begin
                c = '0;
                for (int i = 0; i < width - 1; i++) begin
                    c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
                end
            end
            assign S = A ^ B ^ c;
        end else begin : g_fast
            assign S = A + B;
        end
    endgenerate

endmodule

// File: rtl/csa_row.sv
// One 3:2 compressor row: bitwise sum plus majority carry shifted
// left by one (MSB dropped, LSB zero).
module csa_row #(
    parameter int width = 8
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic [width-1:0] C,
    output logic [width-1:0] S,
    output logic [width-1:0] CS
);

    assign S = A ^ B ^ C;

    assign CS = {(A[width-2:0] & B[width-2:0]) |
                 (A[width-2:0] & C[width-2:0]) |
                 (B[width-2:0] & C[width-2:0]), 1'b0};

endmodule

// File: rtl/acc_csv_sgn.sv
// Signed frame accumulator: carry-save accumulate per beat, one
// resolve cycle at frame close, saturated result over valid/ready.
module acc_csv_sgn
    import acc_pkg::*;
#(
    parameter int widthP = 16,
    parameter int widthA = 24,
    parameter int widthN = 8,
    parameter int speed  = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [widthP-1:0] IN_P,
    input  logic              IN_LAST,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [widthA-1:0] OUT_ACC,
    output logic [widthN-1:0] OUT_CNT,
    output logic              OUT_OVF
);

    localparam int WI = width_i(widthP, widthN);
    localparam logic [widthN-1:0] CNT_LAST = {{(widthN-1){1'b1}}, 1'b0};

    state_t state, state_nx;

    logic [WI-1:0]     as_q, ac_q, res_q;
    logic [WI-1:0]     ext, s_nx, c_nx, sum;
    logic [widthN-1:0] cnt_q, out_cnt_q;
    logic              accept, close;

    assign ext = {{widthN{IN_P[widthP-1]}}, IN_P};

    csa_row #(.width(WI)) u_csa (
        .A  (as_q),
        .B  (ac_q),
        .C  (ext),
        .S  (s_nx),
        .CS (c_nx)
    );

    Add #(.width(WI), .speed(speed)) u_add (
        .A (as_q),
        .B (ac_q),
        .S (sum)
    );

    assign IN_READY  = (state == ACCUM);
    assign OUT_VALID = (state == HOLD);
    assign accept    = IN_VALID & IN_READY;
    // Forced close when this beat brings the count to its maximum.
    assign close     = accept & (IN_LAST | (cnt_q == CNT_LAST));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= ACCUM;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACCUM:   if (close) state_nx = RESOLVE;
            RESOLVE: state_nx = HOLD;
            HOLD:    if (OUT_READY) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            as_q      <= '0;
            ac_q      <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            out_cnt_q <= '0;
        end else if (accept) begin
            as_q  <= s_nx;
            ac_q  <= c_nx;
            cnt_q <= cnt_q + 1'b1;
        end else if (state == RESOLVE) begin
            res_q     <= sum;
            out_cnt_q <= cnt_q;
            as_q      <= '0;
            ac_q      <= '0;
            cnt_q     <= '0;
        end
    end

    assign OUT_CNT = out_cnt_q;

    generate
        if (widthA >= WI) begin : g_wide
            assign OUT_ACC = widthA'($signed(res_q));
            assign OUT_OVF = 1'b0;
        end else begin : g_sat
            localparam logic signed [WI-1:0] MAXP = WI'(sat_max(widthA));
            localparam logic signed [WI-1:0] MINN = WI'(sat_min(widthA));
            logic hi, lo;
            assign hi = $signed(res_q) > MAXP;
            assign lo = $signed(res_q) < MINN;
            assign OUT_ACC = hi ? MAXP[widthA-1:0] :
                             lo ? MINN[widthA-1:0] : res_q[widthA-1:0];
            assign OUT_OVF = hi | lo;
        end
    endgenerate

endmodule

// File: tb/tb_acc_csv_sgn.sv
// Bench for acc_csv_sgn: a 24-bit and a 16-bit result instance share
// one stimulus stream and are checked against an integer-sum model.
module tb_acc_csv_sgn;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_last, out_ready;
    logic [15:0] in_p;

    logic rdy_a, rdy_b, vld_a, vld_b, ovf_a, ovf_b;
    logic signed [23:0] acc_a;
    logic signed [15:0] acc_b;
    logic [7:0] cnt_a, cnt_b;

    int n_chk = 0;
    int n_fail = 0;
    int q[$];

    always #5 clk = ~clk;

    acc_csv_sgn #(.widthP(16), .widthA(24), .widthN(8), .speed(0)) dut (
        .CLK(clk), .RSTn(rst_n),
        .IN_VALID(in_valid), .IN_READY(rdy_a),
        .IN_P(in_p), .IN_LAST(in_last),
        .OUT_VALID(vld_a), .OUT_READY(out_ready),
        .OUT_ACC(acc_a), .OUT_CNT(cnt_a), .OUT_OVF(ovf_a)
    );

    acc_csv_sgn #(.widthP(16), .widthA(16), .widthN(8), .speed(2)) dut16 (
        .CLK(clk), .RSTn(rst_n),
        .IN_VALID(in_valid), .IN_READY(rdy_b),
        .IN_P(in_p), .IN_LAST(in_last),
        .OUT_VALID(vld_b), .OUT_READY(out_ready),
        .OUT_ACC(acc_b), .OUT_CNT(cnt_b), .OUT_OVF(ovf_b)
    );

    function automatic longint sat(input longint s, input int wa);
        longint mx, mn;
        mx = (longint'(1) <<< (wa - 1)) - 1;
        mn = -(longint'(1) <<< (wa - 1));
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
    endfunction

    function automatic longint qsum();
        longint s = 0;
        foreach (q[i]) s += longint'(q[i]);
        return s;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start at a negedge; ends at the negedge of the RESOLVE cycle.
    task automatic drive_beats(input bit use_last);
        foreach (q[i]) begin
            in_valid = 1'b1;
            in_p     = 16'(q[i]);
            in_last  = use_last && (i == q.size() - 1);
            if (i == 0 || i == q.size() - 1) chk("in_ready_accum", rdy_a, 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_frame(input int bp);
        longint s, e24, e16;
        s   = qsum();
        e24 = sat(s, 24);
        e16 = sat(s, 16);
        chk("resolve_in_ready", rdy_a, 0);
        chk("resolve_out_valid", vld_a, 0);
        out_ready = (bp == 0);
        @(negedge clk);
        chk("hold_valid_a", vld_a, 1);
        chk("hold_valid_b", vld_b, 1);
        chk("acc24", acc_a, e24);
        chk("ovf24", ovf_a, longint'(e24 != s));
        chk("cnt", cnt_a, longint'(q.size()));
        chk("acc16", acc_b, e16);
        chk("ovf16", ovf_b, longint'(e16 != s));
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'b1;
            in_p     = 16'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            chk("bp_valid", vld_a, 1);
            chk("bp_in_ready", rdy_a, 0);
            chk("bp_acc_stable", acc_a, e24);
            chk("bp_cnt_stable", cnt_b, longint'(q.size()));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", vld_a, 0);
        chk("post_hs_in_ready", rdy_b, 1);
        chk("post_hs_acc_kept", acc_a, e24);
        chk("post_hs_cnt_kept", cnt_a, longint'(q.size()));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, rdy_a, 1);
        chk({tag, "_out_valid"}, vld_a, 0);
        chk({tag, "_acc"}, acc_a, 0);
        chk({tag, "_cnt"}, cnt_a, 0);
        chk({tag, "_ovf"}, ovf_b, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_p      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("rst");
        rst_n = 1'b1;
        @(negedge clk);
        reset_checks("rst_rel");

        q = '{100, -300, 7};
        drive_beats(1'b1);
        finish_frame(0);

        q = {};
        for (int i = 0; i < 255; i++) q.push_back(-32768);
        drive_beats(1'b0);
        finish_frame(0);

        q = '{30000, 30000};
        drive_beats(1'b1);
        finish_frame(1);
        q = '{-30000, -30000};
        drive_beats(1'b1);
        finish_frame(0);
        q = '{30000, -30000};
        drive_beats(1'b1);
        finish_frame(0);

        q = '{12, -4, 9};
        drive_beats(1'b1);
        finish_frame(5);
        q = '{1};
        drive_beats(1'b1);
        finish_frame(0);

        q = '{1000, 2000};
        drive_beats(1'b0);
        #2 rst_n = 1'b0;
        #1 reset_checks("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q = '{5};
        drive_beats(1'b1);
        finish_frame(0);

        q = '{-7, 3};
        drive_beats(1'b1);
        @(negedge clk);
        chk("hold_before_rst", vld_a, 1);
        #2 rst_n = 1'b0;
        #1 reset_checks("hold_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int f = 0; f < 20; f++) begin
            int len;
            len = int'($urandom_range(1, 12));
            q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0)
                    q.push_back(($urandom_range(0, 1) == 1) ? 32767 : -32768);
                else
                    q.push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            drive_beats(1'b1);
            finish_frame(int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
